// File: rtl/page_pkg.sv
// Shared types and helpers for the page stream bridge.
package page_pkg;

   localparam int PAGE_PAYLOAD_BITS = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } page_state_t;

   function automatic int page_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/page_hs_fifo.sv
// Per-channel vld/ack skid FIFO with a registered accept and a registered head word.
module page_hs_fifo #(
   parameter int W          = 32,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] in_data,
   input  logic         in_vld,
   output logic         in_ack,
   output logic [W-1:0] out_data,
   output logic         out_vld,
   input  logic         out_ack
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

   logic [W-1:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]     cnt_q, cnt_d;
   logic                    ack_q, ack_d;
   logic [W-1:0]            dout_q, dout_d;
   logic                    push, pop;

   assign push     = in_vld && ack_q;
   assign pop      = out_vld && out_ack;
   assign in_ack   = ack_q;
   assign out_vld  = (cnt_q != '0);
   assign out_data = dout_q;

   // Next pointers/occupancy; head word is looked up ahead so it is registered on output.
   // When the new head is the slot being written this cycle, take it straight from the input.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      dout_d   = dout_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
      ack_d = (cnt_d != FULL_CNT);
      if (cnt_d != '0) begin
         if (push && (wr_ptr_q == rd_ptr_d)) dout_d = in_data;
         else                                 dout_d = mem_q[rd_ptr_d];
      end
   end

   // Storage array; stale contents are harmless once pointers are reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

   // Control state and output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ack_q    <= 1'b0;
         dout_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ack_q    <= ack_d;
         dout_q   <= dout_d;
      end
   end

endmodule

// File: rtl/page_stream_bridge.sv
// Page shell: per-stream skid FIFOs plus kernel start/drain sequencing.
//  state | meaning
//  IDLE  | waiting for ap_start, kernel not started
//  RUN   | kern_start high, counting kern_done pulses
//  DRAIN | kernel finished, waiting for output FIFOs and kernel outputs to go quiet
module page_stream_bridge
   import page_pkg::*;
#(
   parameter int PAYLOAD_BITS    = PAGE_PAYLOAD_BITS,
   parameter int NUM_IN_PORTS    = 1,
   parameter int NUM_OUT_PORTS   = 1,
   parameter int FIFO_DEPTH_LOG2 = 2,
   parameter int CNT_BITS        = 16,
   parameter int AUTO_RESTART    = 1
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    ap_start,
   input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    if_dout,
   input  logic [NUM_IN_PORTS-1:0]                 if_vld,
   output logic [NUM_IN_PORTS-1:0]                 if_ack,
   output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    kin_data,
   output logic [NUM_IN_PORTS-1:0]                 kin_vld,
   input  logic [NUM_IN_PORTS-1:0]                 kin_ack,
   input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   kout_data,
   input  logic [NUM_OUT_PORTS-1:0]                kout_vld,
   output logic [NUM_OUT_PORTS-1:0]                kout_ack,
   output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   if_din,
   output logic [NUM_OUT_PORTS-1:0]                if_out_vld,
   input  logic [NUM_OUT_PORTS-1:0]                if_out_ack,
   output logic                                    kern_start,
   input  logic                                    kern_done,
   output logic                                    busy,
   output logic [CNT_BITS-1:0]                     run_count
);

   page_state_t         state_q, state_d;
   logic [CNT_BITS-1:0] run_count_q, run_count_d;
   logic                out_idle;

   for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
      page_hs_fifo #(.W(PAYLOAD_BITS), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
         .clk      (clk),
         .reset    (reset),
         .in_data  (if_dout[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .in_vld   (if_vld[i]),
         .in_ack   (if_ack[i]),
         .out_data (kin_data[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .out_vld  (kin_vld[i]),
         .out_ack  (kin_ack[i])
      );
   end

   for (genvar i = 0; i < NUM_OUT_PORTS; i++) begin : g_out
      page_hs_fifo #(.W(PAYLOAD_BITS), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
         .clk      (clk),
         .reset    (reset),
         .in_data  (kout_data[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .in_vld   (kout_vld[i]),
         .in_ack   (kout_ack[i]),
         .out_data (if_din[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .out_vld  (if_out_vld[i]),
         .out_ack  (if_out_ack[i])
      );
   end

   assign out_idle   = (if_out_vld == '0) && (kout_vld == '0);
   assign kern_start = (state_q == RUN);
   assign busy       = (state_q != IDLE);
   assign run_count  = run_count_q;

   // Sequencing; dropping ap_start mid-run only suppresses the restart.
   always_comb begin
      state_d     = state_q;
      run_count_d = run_count_q;
      case (state_q)
         IDLE:  if (ap_start) state_d = RUN;
         RUN: begin
            if (kern_done) begin
               if (run_count_q != '1) run_count_d = run_count_q + 1'b1;
               if (!((AUTO_RESTART != 0) && ap_start)) state_d = DRAIN;
            end
         end
         DRAIN: if (out_idle) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM and run counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         run_count_q <= '0;
      end else begin
         state_q     <= state_d;
         run_count_q <= run_count_d;
      end
   end

endmodule

// File: tb/tb_page_stream_bridge.sv
// Directed bench for page_stream_bridge with a queue-based reference model.
module tb_page_stream_bridge;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // Instance A: two input streams, one output, single run per start.
   logic        ap_start_a, kern_done_a, kern_start_a, busy_a;
   logic [63:0] if_dout_a, kin_data_a;
   logic [1:0]  if_vld_a, if_ack_a, kin_vld_a, kin_ack_a;
   logic [31:0] kout_data_a, if_din_a;
   logic        kout_vld_a, kout_ack_a, if_out_vld_a, if_out_ack_a;
   logic [15:0] run_count_a;

   // Instance B: auto-restart with a narrow counter to reach saturation.
   logic        ap_start_b, kern_done_b, kern_start_b, busy_b;
   logic [31:0] if_dout_b, kin_data_b, kout_data_b, if_din_b;
   logic        if_vld_b, if_ack_b, kin_vld_b, kin_ack_b;
   logic        kout_vld_b, kout_ack_b, if_out_vld_b, if_out_ack_b;
   logic [2:0]  run_count_b;

   page_stream_bridge #(.PAYLOAD_BITS(32), .NUM_IN_PORTS(2), .NUM_OUT_PORTS(1),
                        .FIFO_DEPTH_LOG2(2), .CNT_BITS(16), .AUTO_RESTART(0)) dut_a (
      .clk(clk), .reset(reset), .ap_start(ap_start_a),
      .if_dout(if_dout_a), .if_vld(if_vld_a), .if_ack(if_ack_a),
      .kin_data(kin_data_a), .kin_vld(kin_vld_a), .kin_ack(kin_ack_a),
      .kout_data(kout_data_a), .kout_vld(kout_vld_a), .kout_ack(kout_ack_a),
      .if_din(if_din_a), .if_out_vld(if_out_vld_a), .if_out_ack(if_out_ack_a),
      .kern_start(kern_start_a), .kern_done(kern_done_a), .busy(busy_a),
      .run_count(run_count_a));

   page_stream_bridge #(.PAYLOAD_BITS(32), .NUM_IN_PORTS(1), .NUM_OUT_PORTS(1),
                        .FIFO_DEPTH_LOG2(2), .CNT_BITS(3), .AUTO_RESTART(1)) dut_b (
      .clk(clk), .reset(reset), .ap_start(ap_start_b),
      .if_dout(if_dout_b), .if_vld(if_vld_b), .if_ack(if_ack_b),
      .kin_data(kin_data_b), .kin_vld(kin_vld_b), .kin_ack(kin_ack_b),
      .kout_data(kout_data_b), .kout_vld(kout_vld_b), .kout_ack(kout_ack_b),
      .if_din(if_din_b), .if_out_vld(if_out_vld_b), .if_out_ack(if_out_ack_b),
      .kern_start(kern_start_b), .kern_done(kern_done_b), .busy(busy_b),
      .run_count(run_count_b));

   int n_cmp = 0;
   int n_bad = 0;
   bit started = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: channels 0,1 = A inputs, 2 = A output, 3 = B input, 4 = B output.
   // FSM state: 0 idle, 1 running, 2 draining.
   logic [31:0] mq [5][$];
   bit          mack [5];
   int          mst [2];
   int          mcnt [2];
   int          cmax [2] = '{65535, 7};
   int          mar [2]  = '{0, 1};
   bit          dr_a, dr_b;

   task automatic fifo_step(input int c, input bit vin, input logic [31:0] din, input bit oack);
      bit push, pop;
      push = vin && mack[c];
      pop  = (mq[c].size() > 0) && oack;
      if (pop)  void'(mq[c].pop_front());
      if (push) mq[c].push_back(din);
      mack[c] = (mq[c].size() < 4);
   endtask

   task automatic fsm_step(input int d, input bit start, input bit done, input bit drained);
      if (mst[d] == 0) begin
         if (start) mst[d] = 1;
      end else if (mst[d] == 1) begin
         if (done) begin
            if (mcnt[d] < cmax[d]) mcnt[d]++;
            if (!(mar[d] != 0 && start)) mst[d] = 2;
         end
      end else begin
         if (drained) mst[d] = 0;
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < 5; c++) begin
            mq[c].delete();
            mack[c] = 1'b0;
         end
         mst[0] = 0; mst[1] = 0; mcnt[0] = 0; mcnt[1] = 0;
      end else begin
         dr_a = (mq[2].size() == 0) && !kout_vld_a;
         dr_b = (mq[4].size() == 0) && !kout_vld_b;
         fifo_step(0, if_vld_a[0], if_dout_a[31:0],  kin_ack_a[0]);
         fifo_step(1, if_vld_a[1], if_dout_a[63:32], kin_ack_a[1]);
         fifo_step(2, kout_vld_a,  kout_data_a,      if_out_ack_a);
         fifo_step(3, if_vld_b,    if_dout_b,        kin_ack_b);
         fifo_step(4, kout_vld_b,  kout_data_b,      if_out_ack_b);
         fsm_step(0, ap_start_a, kern_done_a, dr_a);
         fsm_step(1, ap_start_b, kern_done_b, dr_b);
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (started) begin
         chk("a_if_ack",  64'(if_ack_a),  64'({mack[1], mack[0]}));
         chk("a_kin_vld", 64'(kin_vld_a), 64'({mq[1].size() > 0, mq[0].size() > 0}));
         if (mq[0].size() > 0) chk("a_kin_data0", 64'(kin_data_a[31:0]),  64'(mq[0][0]));
         if (mq[1].size() > 0) chk("a_kin_data1", 64'(kin_data_a[63:32]), 64'(mq[1][0]));
         chk("a_kout_ack",   64'(kout_ack_a),   64'(mack[2]));
         chk("a_if_out_vld", 64'(if_out_vld_a), 64'(mq[2].size() > 0));
         if (mq[2].size() > 0) chk("a_if_din", 64'(if_din_a), 64'(mq[2][0]));
         chk("a_kern_start", 64'(kern_start_a), 64'(mst[0] == 1));
         chk("a_busy",       64'(busy_a),       64'(mst[0] != 0));
         chk("a_run_count",  64'(run_count_a),  64'(mcnt[0]));
         chk("b_if_ack",     64'(if_ack_b),     64'(mack[3]));
         chk("b_kin_vld",    64'(kin_vld_b),    64'(mq[3].size() > 0));
         chk("b_kout_ack",   64'(kout_ack_b),   64'(mack[4]));
         chk("b_if_out_vld", 64'(if_out_vld_b), 64'(mq[4].size() > 0));
         chk("b_kern_start", 64'(kern_start_b), 64'(mst[1] == 1));
         chk("b_busy",       64'(busy_b),       64'(mst[1] != 0));
         chk("b_run_count",  64'(run_count_b),  64'(mcnt[1]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int  idx;
   bit  acc;

   initial begin
      reset = 1'b1;
      ap_start_a = 0; kern_done_a = 0; if_dout_a = '0; if_vld_a = '0; kin_ack_a = '0;
      kout_data_a = '0; kout_vld_a = 0; if_out_ack_a = 0;
      ap_start_b = 0; kern_done_b = 0; if_dout_b = '0; if_vld_b = 0; kin_ack_b = 1;
      kout_data_b = '0; kout_vld_b = 0; if_out_ack_b = 1;

      // 1: reset held three cycles, accept rises one cycle after release
      tick();
      started = 1;
      tick(); tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_if_ack",    64'(if_ack_a),    64'h0);
      chk("rst_kin_vld",   64'(kin_vld_a),   64'h0);
      chk("rst_busy",      64'(busy_a),      64'h0);
      chk("rst_kstart",    64'(kern_start_a),64'h0);
      chk("rst_run_count", 64'(run_count_a), 64'h0);
      tick();
      @(negedge clk);
      chk("post_rst_if_ack",   64'(if_ack_a),   64'h3);
      chk("post_rst_kout_ack", 64'(kout_ack_a), 64'h1);

      // 2: streaming on channel 1, each word one cycle after acceptance
      kin_ack_a = 2'b11;
      for (int k = 0; k < 8; k++) begin
         if_vld_a = 2'b10;
         if_dout_a[63:32] = 32'hA0 + k;
         tick();
         @(negedge clk);
         chk("stream_data", 64'(kin_data_a[63:32]), 64'h0A0 + 64'(k));
         chk("stream_vld",  64'(kin_vld_a), 64'h2);
      end
      if_vld_a = 2'b00;
      tick();
      @(negedge clk);
      chk("stream_empty", 64'(kin_vld_a), 64'h0);

      // 3: backpressure fills the FIFO, one pop reopens it a cycle later
      kin_ack_a = 2'b00;
      idx = 0;
      for (int n = 0; n < 6; n++) begin
         if_vld_a = 2'b10;
         if_dout_a[63:32] = 32'hA0 + idx;
         acc = if_ack_a[1];
         tick();
         if (acc) idx++;
         @(negedge clk);
      end
      chk("bp_accepted", 64'(idx), 64'd4);
      chk("bp_full_ack", 64'(if_ack_a[1]), 64'h0);
      chk("bp_head",     64'(kin_data_a[63:32]), 64'hA0);
      kin_ack_a = 2'b10;
      tick();
      kin_ack_a = 2'b00;
      @(negedge clk);
      chk("bp_ack_back", 64'(if_ack_a[1]), 64'h1);
      chk("bp_head2",    64'(kin_data_a[63:32]), 64'hA1);
      tick();
      @(negedge clk);
      chk("bp_refull",   64'(if_ack_a[1]), 64'h0);
      if_vld_a = 2'b00;
      kin_ack_a = 2'b10;
      repeat (5) tick();
      @(negedge clk);
      chk("bp_drained",  64'(kin_vld_a), 64'h0);
      kin_ack_a = 2'b00;

      // 4: single run, drain waits on two queued output words
      ap_start_a = 1;
      tick();
      ap_start_a = 0;
      @(negedge clk);
      chk("run_kstart", 64'(kern_start_a), 64'h1);
      kout_vld_a = 1; kout_data_a = 32'hB0;
      tick();
      kout_data_a = 32'hB1;
      tick();
      kout_vld_a = 0;
      repeat (6) tick();
      kern_done_a = 1;
      tick();
      kern_done_a = 0;
      @(negedge clk);
      chk("drain_busy",   64'(busy_a),       64'h1);
      chk("drain_kstart", 64'(kern_start_a), 64'h0);
      chk("drain_count",  64'(run_count_a),  64'h1);
      chk("drain_din",    64'(if_din_a),     64'hB0);
      repeat (2) tick();
      @(negedge clk);
      chk("drain_hold",   64'(busy_a),       64'h1);
      if_out_ack_a = 1;
      tick();
      @(negedge clk);
      chk("drain_din2",   64'(if_din_a),     64'hB1);
      tick();
      if_out_ack_a = 0;
      @(negedge clk);
      chk("drain_empty",  64'(if_out_vld_a), 64'h0);
      chk("drain_last",   64'(busy_a),       64'h1);
      tick();
      @(negedge clk);
      chk("idle_busy",    64'(busy_a),       64'h0);
      kern_done_a = 1;
      tick();
      kern_done_a = 0;
      @(negedge clk);
      chk("idle_done_ignored", 64'(run_count_a), 64'h1);

      // 5: auto-restart keeps kern_start high; counter saturates at 7
      ap_start_b = 1;
      tick();
      for (int p = 0; p < 9; p++) begin
         repeat (2) tick();
         kern_done_b = 1;
         tick();
         kern_done_b = 0;
         @(negedge clk);
         chk("ar_kstart", 64'(kern_start_b), 64'h1);
         if (p == 2) chk("ar_count3", 64'(run_count_b), 64'h3);
      end
      chk("ar_saturate", 64'(run_count_b), 64'h7);
      ap_start_b = 0;
      kern_done_b = 1;
      tick();
      kern_done_b = 0;
      @(negedge clk);
      chk("ar_drain_busy",   64'(busy_b),       64'h1);
      chk("ar_drain_kstart", 64'(kern_start_b), 64'h0);
      tick();
      @(negedge clk);
      chk("ar_idle",   64'(busy_b),      64'h0);
      chk("ar_final",  64'(run_count_b), 64'h7);

      // 6: reset in the middle of a run with words queued
      ap_start_a = 1;
      tick();
      ap_start_a = 0;
      for (int k = 0; k < 3; k++) begin
         if_vld_a = 2'b11;
         if_dout_a = {32'hC0 + k, 32'hD0 + k};
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      if_vld_a = 2'b00;
      @(negedge clk);
      chk("mrst_kin_vld", 64'(kin_vld_a),    64'h0);
      chk("mrst_busy",    64'(busy_a),       64'h0);
      chk("mrst_kstart",  64'(kern_start_a), 64'h0);
      chk("mrst_if_ack",  64'(if_ack_a),     64'h0);
      chk("mrst_count",   64'(run_count_a),  64'h0);
      kin_ack_a = 2'b11;
      for (int k = 0; k < 4; k++) begin
         tick();
         @(negedge clk);
         chk("mrst_no_word", 64'(kin_vld_a), 64'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
